lsu_bus_master: RTL and testbench

//  Initiator side of the data-memory interface: accepts one load/store from the core, drives a

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_load_extend.sv | 41 ++++
 rtl/lsu_bus_master.sv | 228 ++++++++++++++++++++++
 tb/tb_lsu_bus_master.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared definitions for the load/store bus master:
//   - RV32I load/store width codes (funct3)
//   - FSM state encoding
//   - lane-index helpers that turn the low address bits into shift amounts
//   No ports.

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Bit offset of the addressed byte lane within a 32-bit word.
    function automatic logic [4:0] byte_shift(input logic [1:0] addr_lo);
        return {addr_lo, 3'b000};
    endfunction

    // Bit offset of the addressed halfword within a 32-bit word.
    function automatic logic [4:0] half_shift(input logic addr_hi);
        return {addr_hi, 4'b0000};
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend
//   Combinational load-data alignment: picks the byte/halfword lane named by
//   the low address bits out of the returned bus word and sign- or
//   zero-extends it according to funct3.
// Ports:
//   word     in  32  word returned by the bus
//   addr_lo  in  2   low byte-address bits of the load
//   funct3   in  3   RV32I load width/sign code
//   result   out 32  extended load result

module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] byte_aligned;
    logic [31:0] half_aligned;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign byte_aligned = word >> byte_shift(addr_lo);
    assign half_aligned = word >> half_shift(addr_lo[1]);
    assign sel_byte     = byte_aligned[7:0];
    assign sel_half     = half_aligned[15:0];

    always_comb begin
        result = word;
        case (funct3)
            F3_B:    result = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   result = {24'h000000, sel_byte};
            F3_H:    result = {{16{sel_half[15]}}, sel_half};
            F3_HU:   result = {16'h0000, sel_half};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master
//   Initiator side of the data-memory interface. Accepts one load or store
//   from the core, issues a word-aligned bus request with byte enables,
//   waits for grant and response, then returns extended load data or a
//   store acknowledge with a one-cycle done pulse. One transaction in flight.
//
//   Build option: define LSU_TIMEOUT_EN to add a per-phase watchdog
//   (TIMEOUT_CYCLES parameter) that aborts REQ or WAIT with lsu_err=1.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   lsu_valid/lsu_ready        core request handshake (ready only in IDLE)
//   lsu_we, lsu_funct3         store flag, RV32I width/sign code
//   lsu_addr, lsu_wdata        byte address, store data
//   lsu_done, lsu_rdata,       completion pulse, load result (held),
//   lsu_err                    error flag valid with done
//   bus_req/bus_gnt            request held until grant
//   bus_we, bus_addr, bus_be,  write strobe, word address, byte enables,
//   bus_wdata                  lane-replicated store data
//   bus_rvalid, bus_rdata      one-cycle response / read data
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a core request
// REQ   | bus_req asserted, waiting for bus_gnt
// WAIT  | request granted, waiting for bus_rvalid
// DONE  | lsu_done pulse (with lsu_err / lsu_rdata valid), back to IDLE

module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic                    lsu_we,
    input  logic [2:0]              lsu_funct3,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    output logic                    lsu_done,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    lsu_err,

    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH/8-1:0] bus_be,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_gnt,
    input  logic                    bus_rvalid,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    lsu_state_t state;

    // Registered copy of the accepted request, needed for load extraction.
    logic       we_q;
    logic [1:0] addr_lo_q;
    logic [2:0] funct3_q;

    logic                    misaligned;
    logic                    illegal;
    logic [DATA_WIDTH/8-1:0] be_next;
    logic [DATA_WIDTH-1:0]   wdata_next;
    logic [DATA_WIDTH-1:0]   load_result;

`ifdef LSU_TIMEOUT_EN
    localparam int          TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Loaded with N-1 so the terminal count (zero) is seen on the Nth cycle.
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`endif

    always_comb begin
        misaligned = 1'b0;
        case (lsu_funct3)
            F3_H, F3_HU: misaligned = lsu_addr[0];
            F3_W:        misaligned = (lsu_addr[1:0] != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        if (lsu_we)
            illegal = !(lsu_funct3 inside {F3_B, F3_H, F3_W});
        else
            illegal = (lsu_funct3 inside {3'b011, 3'b110, 3'b111});
    end

    // funct3[1:0] is the access size for both signed and unsigned codes.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = lsu_wdata;
        case (lsu_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << lsu_addr[1:0];
                wdata_next = {4{lsu_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = lsu_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{lsu_wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = lsu_wdata;
            end
        endcase
    end

    lsu_load_extend u_load_extend (
        .word    (bus_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .result  (load_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            lsu_ready <= 1'b1;
            lsu_done  <= 1'b0;
            lsu_err   <= 1'b0;
            lsu_rdata <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            we_q      <= 1'b0;
            addr_lo_q <= 2'b00;
            funct3_q  <= 3'b000;
`ifdef LSU_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lsu_valid) begin
                        we_q      <= lsu_we;
                        addr_lo_q <= lsu_addr[1:0];
                        funct3_q  <= lsu_funct3;
                        lsu_ready <= 1'b0;
                        if (misaligned || illegal) begin
                            // Rejected without touching the bus.
                            state    <= ST_DONE;
                            lsu_done <= 1'b1;
                            lsu_err  <= 1'b1;
                        end else begin
                            state     <= ST_REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= lsu_we;
                            bus_addr  <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
                            bus_be    <= be_next;
                            bus_wdata <= wdata_next;
`ifdef LSU_TIMEOUT_EN
                            to_cnt    <= TO_LOAD;
`endif
                        end
                    end
                end

                ST_REQ: begin
                    if (bus_gnt) begin
                        state   <= ST_WAIT;
                        bus_req <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                        to_cnt  <= TO_LOAD;
`endif
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (to_cnt == '0) begin
                        state    <= ST_DONE;
                        bus_req  <= 1'b0;
                        lsu_done <= 1'b1;
                        lsu_err  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
`endif
                end

                ST_WAIT: begin
                    if (bus_rvalid) begin
                        state    <= ST_DONE;
                        lsu_done <= 1'b1;
                        lsu_err  <= 1'b0;
                        if (!we_q)
                            lsu_rdata <= load_result;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (to_cnt == '0) begin
                        state    <= ST_DONE;
                        lsu_done <= 1'b1;
                        lsu_err  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
`endif
                end

                ST_DONE: begin
                    state     <= ST_IDLE;
                    lsu_done  <= 1'b0;
                    lsu_err   <= 1'b0;
                    lsu_ready <= 1'b1;
                end

                default: begin
                    state     <= ST_IDLE;
                    lsu_done  <= 1'b0;
                    lsu_err   <= 1'b0;
                    lsu_ready <= 1'b1;
                    bus_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master
//   Directed self-checking bench for lsu_bus_master. Each task drives one
//   scenario and compares outputs against hand-computed values.
//   Define LSU_TIMEOUT_EN for both bench and RTL to exercise the watchdog.

module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    lsu_bus_master dut (
        .clk        (clk),
        .reset      (reset),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_we     (lsu_we),
        .lsu_funct3 (lsu_funct3),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_done   (lsu_done),
        .lsu_rdata  (lsu_rdata),
        .lsu_err    (lsu_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    // Present one request for a single edge; returns 1ns after the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        lsu_valid  = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = addr;
        lsu_wdata  = wdata;
        @(posedge clk); #1;
        lsu_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({lsu_ready, lsu_done, lsu_err, bus_req, bus_we, bus_be} !== 9'b1_0_0_0_0_0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=%b",
                     {lsu_ready, lsu_done, lsu_err, bus_req, bus_we, bus_be}, 9'b100000000);
        end
        total++;
        if ({lsu_rdata, bus_addr, bus_wdata} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {lsu_rdata, bus_addr, bus_wdata});
        end
        reset = 1'b0;
        last_rdata = 32'h0;
        @(posedge clk); #1;
    endtask

    // SB with immediate grant: checks request fields and minimum latency.
    task automatic test_sb_timing();
        issue(1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB);
        total++;
        if ({lsu_ready, bus_req, bus_we, bus_be} !== 7'b0_1_1_1000) begin
            bad++;
            $display("FAIL sb_req got=%b exp=%b", {lsu_ready, bus_req, bus_we, bus_be}, 7'b0111000);
        end
        total++;
        if ({bus_addr, bus_wdata} !== {32'h0000_0100, 32'hABAB_ABAB}) begin
            bad++;
            $display("FAIL sb_addr_wdata got=%h exp=%h", {bus_addr, bus_wdata},
                     {32'h0000_0100, 32'hABAB_ABAB});
        end
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        total++;
        if ({bus_req, lsu_done} !== 2'b00) begin
            bad++;
            $display("FAIL sb_wait got=%b exp=00", {bus_req, lsu_done});
        end
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        total++;
        if ({lsu_done, lsu_err, lsu_rdata} !== {2'b10, last_rdata}) begin
            bad++;
            $display("FAIL sb_done got=%h exp=%h", {lsu_done, lsu_err, lsu_rdata}, {2'b10, last_rdata});
        end
        @(posedge clk); #1;
        total++;
        if ({lsu_done, lsu_ready} !== 2'b01) begin
            bad++;
            $display("FAIL sb_idle got=%b exp=01", {lsu_done, lsu_ready});
        end
    endtask

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } ld_vec_t;

    task automatic test_loads();
        ld_vec_t lv [8];
        lv[0] = '{3'b000, 32'h0000_0102, 32'h0080_0000, 4'b0100, 32'hFFFF_FF80};
        lv[1] = '{3'b100, 32'h0000_0102, 32'h0080_0000, 4'b0100, 32'h0000_0080};
        lv[2] = '{3'b001, 32'h0000_0102, 32'h8001_0000, 4'b1100, 32'hFFFF_8001};
        lv[3] = '{3'b101, 32'h0000_0102, 32'h8001_0000, 4'b1100, 32'h0000_8001};
        lv[4] = '{3'b010, 32'h0000_0104, 32'h1234_5678, 4'b1111, 32'h1234_5678};
        lv[5] = '{3'b000, 32'h0000_0100, 32'h0000_007F, 4'b0001, 32'h0000_007F};
        lv[6] = '{3'b001, 32'h0000_0100, 32'h0000_F00D, 4'b0011, 32'hFFFF_F00D};
        lv[7] = '{3'b000, 32'h0000_0103, 32'h9A00_0000, 4'b1000, 32'hFFFF_FF9A};
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, lv[i].f3, lv[i].addr, 32'h5555_AAAA);
            total++;
            if ({bus_req, bus_we, bus_be, bus_addr} !== {2'b10, lv[i].be, lv[i].addr & 32'hFFFF_FFFC}) begin
                bad++;
                $display("FAIL load_req[%0d] got=%h exp=%h", i, {bus_req, bus_we, bus_be, bus_addr},
                         {2'b10, lv[i].be, lv[i].addr & 32'hFFFF_FFFC});
            end
            bus_gnt = 1'b1;
            @(posedge clk); #1;
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b1;
            bus_rdata  = lv[i].rdata;
            @(posedge clk); #1;
            bus_rvalid = 1'b0;
            total++;
            if ({lsu_done, lsu_err, lsu_rdata} !== {2'b10, lv[i].exp}) begin
                bad++;
                $display("FAIL load_data[%0d] got=%h exp=%h", i, {lsu_done, lsu_err, lsu_rdata},
                         {2'b10, lv[i].exp});
            end
            last_rdata = lv[i].exp;
            @(posedge clk); #1;
        end
    endtask

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] bwdata;
    } st_vec_t;

    task automatic test_stores();
        st_vec_t sv [4];
        sv[0] = '{3'b001, 32'h0000_0302, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF};
        sv[1] = '{3'b001, 32'h0000_0300, 32'h1234_BEEF, 4'b0011, 32'hBEEF_BEEF};
        sv[2] = '{3'b000, 32'h0000_0101, 32'h0000_00C3, 4'b0010, 32'hC3C3_C3C3};
        sv[3] = '{3'b010, 32'h0000_040C, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, sv[i].f3, sv[i].addr, sv[i].wdata);
            total++;
            if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !==
                {2'b11, sv[i].be, sv[i].addr & 32'hFFFF_FFFC, sv[i].bwdata}) begin
                bad++;
                $display("FAIL store_req[%0d] got=%h exp=%h", i,
                         {bus_req, bus_we, bus_be, bus_addr, bus_wdata},
                         {2'b11, sv[i].be, sv[i].addr & 32'hFFFF_FFFC, sv[i].bwdata});
            end
            bus_gnt = 1'b1;
            @(posedge clk); #1;
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            bus_rvalid = 1'b0;
            total++;
            if ({lsu_done, lsu_err, lsu_rdata} !== {2'b10, last_rdata}) begin
                bad++;
                $display("FAIL store_done[%0d] got=%h exp=%h", i, {lsu_done, lsu_err, lsu_rdata},
                         {2'b10, last_rdata});
            end
            @(posedge clk); #1;
        end
    endtask

    // Misaligned and illegal requests: error done one edge after accept, no bus traffic.
    task automatic test_misaligned();
        logic        we_t [8];
        logic [2:0]  f3_t [8];
        logic [31:0] ad_t [8];
        we_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        f3_t = '{3'b001, 3'b010, 3'b101, 3'b010, 3'b001, 3'b100, 3'b011, 3'b110};
        ad_t = '{32'h101, 32'h102, 32'h103, 32'h101, 32'h103, 32'h100, 32'h100, 32'h100};
        for (int i = 0; i < 8; i++) begin
            issue(we_t[i], f3_t[i], ad_t[i], 32'h0BAD_0BAD);
            total++;
            if ({bus_req, lsu_done, lsu_err, lsu_ready, lsu_rdata} !== {4'b0110, last_rdata}) begin
                bad++;
                $display("FAIL err_done[%0d] got=%h exp=%h", i,
                         {bus_req, lsu_done, lsu_err, lsu_ready, lsu_rdata}, {4'b0110, last_rdata});
            end
            @(posedge clk); #1;
            total++;
            if ({bus_req, lsu_done, lsu_err, lsu_ready} !== 4'b0001) begin
                bad++;
                $display("FAIL err_idle[%0d] got=%b exp=0001", i,
                         {bus_req, lsu_done, lsu_err, lsu_ready});
            end
        end
    endtask

    // SW with grant held off 5 cycles; a request offered mid-flight must be dropped.
    task automatic test_sw_gnt_delay();
        int pulses;
        issue(1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D);
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !==
                {2'b11, 4'b1111, 32'h0000_0200, 32'hCAFE_F00D}) begin
                bad++;
                $display("FAIL sw_hold[%0d] got=%h exp=%h", i,
                         {bus_req, bus_we, bus_be, bus_addr, bus_wdata},
                         {2'b11, 4'b1111, 32'h0000_0200, 32'hCAFE_F00D});
            end
            if (i == 2) begin
                lsu_valid  = 1'b1;
                lsu_we     = 1'b0;
                lsu_funct3 = 3'b010;
                lsu_addr   = 32'h0000_0700;
            end
            if (i == 3) lsu_valid = 1'b0;
            if (i == 5) bus_gnt = 1'b1;
            @(posedge clk); #1;
        end
        bus_gnt = 1'b0;
        total++;
        if (bus_req !== 1'b0) begin
            bad++;
            $display("FAIL sw_req_drop got=%b exp=0", bus_req);
        end
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1111_1111;
        pulses = 0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            bus_rvalid = 1'b0;
            if (lsu_done) pulses++;
        end
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL sw_pulses got=%0d exp=1", pulses);
        end
        total++;
        if ({lsu_ready, bus_req, lsu_rdata} !== {2'b10, last_rdata}) begin
            bad++;
            $display("FAIL sw_after got=%h exp=%h", {lsu_ready, bus_req, lsu_rdata}, {2'b10, last_rdata});
        end
    endtask

    // Grant/response strobes while idle must be ignored.
    task automatic test_stray();
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        total++;
        if ({lsu_done, bus_req, lsu_ready, lsu_rdata} !== {3'b001, last_rdata}) begin
            bad++;
            $display("FAIL stray got=%h exp=%h", {lsu_done, bus_req, lsu_ready, lsu_rdata},
                     {3'b001, last_rdata});
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        reset   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if ({bus_req, lsu_ready, lsu_done} !== 3'b010) begin
            bad++;
            $display("FAIL rst_mid got=%b exp=010", {bus_req, lsu_ready, lsu_done});
        end
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h7777_7777;
        pulses = 0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            bus_rvalid = 1'b0;
            if (lsu_done) pulses++;
        end
        total++;
        if ({pulses[3:0], lsu_ready, lsu_rdata} !== {4'd0, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL rst_late_rvalid got=%h exp=%h", {pulses[3:0], lsu_ready, lsu_rdata},
                     {4'd0, 1'b1, 32'h0});
        end
        issue(1'b0, 3'b100, 32'h0000_0503, 32'h0);
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hC500_0000;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        total++;
        if ({lsu_done, lsu_err, lsu_rdata} !== {2'b10, 32'h0000_00C5}) begin
            bad++;
            $display("FAIL rst_recover got=%h exp=%h", {lsu_done, lsu_err, lsu_rdata},
                     {2'b10, 32'h0000_00C5});
        end
        last_rdata = 32'h0000_00C5;
        @(posedge clk); #1;
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        issue(1'b0, 3'b010, 32'h0000_0600, 32'h0);
        n = 0;
        while (!lsu_done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL timeout_cycles got=%0d exp=16", n);
        end
        total++;
        if ({lsu_done, lsu_err, bus_req, lsu_rdata} !== {3'b110, last_rdata}) begin
            bad++;
            $display("FAIL timeout_err got=%h exp=%h", {lsu_done, lsu_err, bus_req, lsu_rdata},
                     {3'b110, last_rdata});
        end
        @(posedge clk); #1;
    endtask
`else
    // Without the watchdog a long grant stall must still complete cleanly.
    task automatic test_timeout();
        issue(1'b0, 3'b010, 32'h0000_0600, 32'h0);
        repeat (30) @(posedge clk);
        #1;
        total++;
        if ({bus_req, lsu_done, lsu_err} !== 3'b100) begin
            bad++;
            $display("FAIL stall_hold got=%b exp=100", {bus_req, lsu_done, lsu_err});
        end
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        total++;
        if ({lsu_done, lsu_err, lsu_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
            bad++;
            $display("FAIL stall_done got=%h exp=%h", {lsu_done, lsu_err, lsu_rdata},
                     {2'b10, 32'h0BAD_F00D});
        end
        last_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        lsu_valid  = 1'b0;
        lsu_we     = 1'b0;
        lsu_funct3 = 3'b000;
        lsu_addr   = 32'h0;
        lsu_wdata  = 32'h0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        last_rdata = 32'h0;
        test_reset();
        test_sb_timing();
        test_loads();
        test_stores();
        test_misaligned();
        test_sw_gnt_delay();
        test_stray();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule
